seq_detector_param: RTL and testbench

- Parametrised serial sequence detector; successor to the fixed-pattern Moore/Mealy detectors.
- Sits downstream of par2ser and consumes the data_serial/data_valid stream.
- Runtime-programmable pattern of PATTERN_LEN bits, selectable overlapping or non-overlapping matching.
- Mealy and Moore detect outputs from one core, plus an on-chip saturating detection counter, so benches no longer need their own counting.

---
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with Mealy/Moore
// detect outputs and a saturating detection counter.
`default_nettype none

module seq_detector_param #(
  parameter int                     PATTERN_LEN   = 4,
  parameter int                     COUNT_WIDTH   = 16,
  parameter logic [PATTERN_LEN-1:0] RESET_PATTERN = 4'b1011
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   data_serial,
  input  logic                   data_valid,
  input  logic [PATTERN_LEN-1:0] cfg_pattern,
  input  logic                   cfg_load,
  input  logic                   cfg_overlap,
  input  logic                   count_clear,
  output logic                   detected_mealy,
  output logic                   detected_moore,
  output logic [COUNT_WIDTH-1:0] det_count,
  output logic                   count_sat
);

  localparam int                FILL_W   = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
  logic [PATTERN_LEN-2:0] history_q, history_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   moore_q, moore_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   sat_q, sat_d;

  // Window of the last PATTERN_LEN bits including the bit on the wire this cycle.
  logic [PATTERN_LEN-1:0] window;
  logic                   match;

  assign window = {history_q, data_serial};
  assign match  = data_valid & ~cfg_load & (fill_q == FILL_MAX) & (window == pattern_q);

  always_comb begin
    pattern_d = pattern_q;
    history_d = history_q;
    fill_d    = fill_q;
    moore_d   = match;
    count_d   = count_q;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      history_d = '0;
      fill_d    = '0;
    end else if (data_valid) begin
      if (match && !cfg_overlap) begin
        history_d = '0;
        fill_d    = '0;
      end else begin
        history_d = window[PATTERN_LEN-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
    end

    // A clear beats a coincident match; the match still shows on the detect outputs.
    if (count_clear) begin
      count_d = '0;
    end else if (match && !sat_q) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
    sat_d = &count_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= RESET_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      moore_q   <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      moore_q   <= moore_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  assign detected_mealy = match;
  assign detected_moore = moore_q;
  assign det_count      = count_q;
  assign count_sat      = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed vectors with hand-computed detects.
`default_nettype none

module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       data_serial = 1'b0;
  logic       data_valid = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       cfg_load = 1'b0;
  logic       cfg_overlap = 1'b1;
  logic       count_clear = 1'b0;
  logic       detected_mealy;
  logic       detected_moore;
  logic [2:0] det_count;
  logic       count_sat;

  seq_detector_param #(
    .PATTERN_LEN  (4),
    .COUNT_WIDTH  (3),
    .RESET_PATTERN(4'b1011)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_serial   (data_serial),
    .data_valid    (data_valid),
    .cfg_pattern   (cfg_pattern),
    .cfg_load      (cfg_load),
    .cfg_overlap   (cfg_overlap),
    .count_clear   (count_clear),
    .detected_mealy(detected_mealy),
    .detected_moore(detected_moore),
    .det_count     (det_count),
    .count_sat     (count_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [2:0] cnt;
    logic       sat;
    int         id;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         step_id = 0;
  logic [2:0] exp_cnt = 3'd0;
  logic       ovl_sel = 1'b1;

  task automatic check(input string name, input int id, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, id, got, exp);
    end
  endtask

  // One stimulus cycle; the hand-computed Mealy detect determines Moore and the counter.
  task automatic step(input logic v, input logic d, input logic ld, input logic [3:0] pat,
                      input logic clr, input logic exp_m);
    exp_t e;
    @(posedge clk);
    #2;
    data_valid  = v;
    data_serial = d;
    cfg_load    = ld;
    cfg_pattern = pat;
    count_clear = clr;
    cfg_overlap = ovl_sel;
    if (clr) exp_cnt = 3'd0;
    else if (exp_m && exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
    e.m   = exp_m;
    e.cnt = exp_cnt;
    e.sat = (exp_cnt == 3'd7);
    e.id  = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  task automatic bit_in(input logic d, input logic exp_m);
    step(1'b1, d, 1'b0, 4'b0000, 1'b0, exp_m);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [3:0] pat);
    step(1'b0, 1'b0, 1'b1, pat, 1'b0, 1'b0);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic bits(input logic [15:0] d, input logic [15:0] m, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(d[i], m[i]);
  endtask

  // Monitor: Mealy checked mid-cycle, registered outputs just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("mealy", e.id, {2'b00, detected_mealy}, {2'b00, e.m});
        @(posedge clk);
        #1;
        check("moore", e.id, {2'b00, detected_moore}, {2'b00, e.m});
        check("det_count", e.id, det_count, e.cnt);
        check("count_sat", e.id, {2'b00, count_sat}, {2'b00, e.sat});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int wait_cycles;
    #12;
    check("rst_mealy", -1, {2'b00, detected_mealy}, 3'd0);
    check("rst_moore", -1, {2'b00, detected_moore}, 3'd0);
    check("rst_count", -1, det_count, 3'd0);
    check("rst_sat", -1, {2'b00, count_sat}, 3'd0);
    reset_n = 1'b1;

    // Overlapping 1011 on 1011011: detects on bits 4 and 7.
    ovl_sel = 1'b1;
    bits(16'b1011011, 16'b0001001, 7);
    clear();
    load(4'b1011);

    // Non-overlapping: only bit 4 detects.
    ovl_sel = 1'b0;
    bits(16'b1011011, 16'b0001000, 7);
    clear();

    // All-ones pattern, six 1s: overlap gives three back-to-back detects, else one.
    ovl_sel = 1'b1;
    load(4'b1111);
    bits(16'b111111, 16'b000111, 6);
    ovl_sel = 1'b0;
    load(4'b1111);
    bits(16'b111111, 16'b000100, 6);
    clear();

    // Idle gap is transparent to pattern continuity.
    ovl_sel = 1'b1;
    load(4'b1011);
    bits(16'b10, 16'b00, 2);
    repeat (5) idle();
    bits(16'b11, 16'b01, 2);

    // Load with a coincident valid bit discards it and restarts fill.
    load(4'b1011);
    bits(16'b10, 16'b00, 2);
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
    bits(16'b1011, 16'b0001, 4);
    clear();

    // Saturation: nine detections on a 3-bit counter, then clear against a match.
    load(4'b1111);
    bits(16'b111111111111, 16'b000111111111, 12);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    clear();

    // Async reset between bits 3 and 4 aborts the partial match and restores 1011.
    load(4'b0110);
    load(4'b1011);
    bits(16'b101, 16'b000, 3);
    @(posedge clk);
    #3;
    data_valid  = 1'b1;
    data_serial = 1'b1;
    reset_n     = 1'b0;
    #1;
    check("async_mealy", -2, {2'b00, detected_mealy}, 3'd0);
    check("async_moore", -2, {2'b00, detected_moore}, 3'd0);
    check("async_count", -2, det_count, 3'd0);
    check("async_sat", -2, {2'b00, count_sat}, 3'd0);
    data_valid = 1'b0;
    exp_cnt    = 3'd0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bits(16'b1011, 16'b0001, 4);
    idle();

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
